// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for uart_transceiver.
//   tx_state_t   - transmitter FSM states
//   rx_state_t   - receiver FSM states (RX_BREAK waits for the line to go high
//                  again after a frame whose stop bit was sampled low)
//   parity_calc  - parity bit for a payload (zero-extended to 9 bits)
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    // Bit that makes the total number of ones even (odd = 0) or odd (odd = 1).
    function automatic logic parity_calc(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO holding received payloads.
//   clk, reset   - clock, asynchronous active-high reset (empties the FIFO)
//   push         - write push_data; dropped when full unless a pop happens too
//   pop          - remove head; ignored when empty
//   head         - oldest entry (valid when !empty)
//   full, empty  - occupancy flags
//   count        - occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot being written, so push still goes in at full.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_transceiver.sv
// uart_transceiver: full-duplex UART, 16x-style oversampled receiver with
// mid-bit sampling and glitch-rejecting start detect, RX FIFO, valid/ready TX.
//   clk, reset      - clock, asynchronous active-high reset
//   tx_data/valid   - payload to send; accepted on tx_valid && tx_ready
//   tx_ready        - transmitter idle
//   rx_data/valid   - FIFO head / FIFO not empty; pop on rx_valid && rx_ready
//   rx_count        - FIFO occupancy
//   rx_frame_err    - 1-clk pulse: stop bit sampled low (frame dropped)
//   rx_parity_err   - 1-clk pulse: parity mismatch (frame dropped)
//   rx_overrun      - 1-clk pulse: good frame dropped because FIFO was full
//   uart_rx/uart_tx - serial in (asynchronous) / serial out (idle high)
// Build option: define UART_PARITY_EN to add a parity bit (even, or odd when
// PARITY_ODD != 0) after the data bits in both directions.
module uart_transceiver #(
    parameter int BAUD_DIV      = 54,
    parameter int OVERSAMPLE    = 16,
    parameter int DATA_BITS     = 8,
    parameter int STOP_BITS     = 1,
    parameter int PARITY_ODD    = 0,
    parameter int RX_FIFO_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DATA_BITS-1:0]           tx_data,
    input  logic                           tx_valid,
    output logic                           tx_ready,
    output logic [DATA_BITS-1:0]           rx_data,
    output logic                           rx_valid,
    input  logic                           rx_ready,
    output logic [$clog2(RX_FIFO_DEPTH):0] rx_count,
    output logic                           rx_frame_err,
    output logic                           rx_parity_err,
    output logic                           rx_overrun,
    input  logic                           uart_rx,
    output logic                           uart_tx
);
    import uart_pkg::*;

`ifdef UART_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam int DIVW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int TW   = $clog2(OVERSAMPLE);
    localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(BAUD_DIV - 1);
    localparam logic [TW-1:0]   TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0]   TICK_HALF = TW'(OVERSAMPLE/2 - 1);
    localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic            ODD       = (PARITY_ODD != 0);

    // Oversample tick divider
    logic [DIVW-1:0] div_cnt;
    logic            tick;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) div_cnt <= '0;
        else       div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end

    // Transmitter
    tx_state_t            tx_state;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;
    logic                 tx_go;
    logic [TW-1:0]        tx_tick;
    logic [3:0]           tx_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_go    <= 1'b0;
            tx_tick  <= '0;
            tx_bit   <= '0;
            uart_tx  <= 1'b1;
            tx_ready <= 1'b1;
        end else if (tx_state == TX_IDLE) begin
            if (tx_valid) begin
                tx_shift <= tx_data;
                tx_par   <= parity_calc(9'(tx_data), ODD);
                tx_go    <= 1'b0;
                tx_ready <= 1'b0;
                tx_state <= TX_START;
            end
        end else if (tick) begin
            if (!tx_go) begin
                // First tick after accept opens the start bit, aligning every
                // following bit to whole tick periods.
                tx_go   <= 1'b1;
                tx_tick <= '0;
                uart_tx <= 1'b0;
            end else if (tx_tick != TICK_LAST) begin
                tx_tick <= tx_tick + 1'b1;
            end else begin
                tx_tick <= '0;
                case (tx_state)
                    TX_START: begin
                        tx_state <= TX_DATA;
                        tx_bit   <= '0;
                        uart_tx  <= tx_shift[0];
                    end
                    TX_DATA: begin
                        tx_shift <= tx_shift >> 1;
                        if (tx_bit != DATA_LAST) begin
                            tx_bit  <= tx_bit + 1'b1;
                            uart_tx <= tx_shift[1];
                        end else if (PAR_EN) begin
                            tx_state <= TX_PARITY;
                            uart_tx  <= tx_par;
                        end else begin
                            tx_state <= TX_STOP;
                            tx_bit   <= '0;
                            uart_tx  <= 1'b1;
                        end
                    end
                    TX_PARITY: begin
                        tx_state <= TX_STOP;
                        tx_bit   <= '0;
                        uart_tx  <= 1'b1;
                    end
                    default: begin
                        if (tx_bit != STOP_LAST) begin
                            tx_bit <= tx_bit + 1'b1;
                        end else begin
                            tx_state <= TX_IDLE;
                            tx_ready <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Receiver
    rx_state_t            rx_state;
    logic                 rx_s1;
    logic                 rx_s2;
    logic [TW-1:0]        rx_tick;
    logic [3:0]           rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par_bit;
    logic                 rx_par_bad;
    logic                 rx_done;
    logic                 fifo_full;
    logic                 fifo_empty;

    assign rx_par_bad = PAR_EN && (rx_par_bit != parity_calc(9'(rx_shift), ODD));
    assign rx_valid   = !fifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1         <= 1'b1;
            rx_s2         <= 1'b1;
            rx_state      <= RX_IDLE;
            rx_tick       <= '0;
            rx_bit        <= '0;
            rx_shift      <= '0;
            rx_par_bit    <= 1'b0;
            rx_done       <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_s1         <= uart_rx;
            rx_s2         <= rx_s1;
            rx_done       <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
            // Judged in the cycle the FIFO sees the push, so a same-cycle pop rescues it.
            rx_overrun    <= rx_done && fifo_full && !rx_ready;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_s2) begin
                        rx_state <= RX_START;
                        rx_tick  <= '0;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (rx_tick != TICK_HALF) begin
                            rx_tick <= rx_tick + 1'b1;
                        end else begin
                            rx_tick  <= '0;
                            rx_bit   <= '0;
                            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                        end
                    end
                end
                RX_BREAK: begin
                    if (rx_s2) rx_state <= RX_IDLE;
                end
                default: begin
                    // DATA / PARITY / STOP: one sample per bit, at mid-bit
                    if (tick) begin
                        if (rx_tick != TICK_LAST) begin
                            rx_tick <= rx_tick + 1'b1;
                        end else begin
                            rx_tick <= '0;
                            case (rx_state)
                                RX_DATA: begin
                                    rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                                    if (rx_bit != DATA_LAST)
                                        rx_bit <= rx_bit + 1'b1;
                                    else
                                        rx_state <= PAR_EN ? RX_PARITY : RX_STOP;
                                end
                                RX_PARITY: begin
                                    rx_par_bit <= rx_s2;
                                    rx_state   <= RX_STOP;
                                end
                                default: begin
                                    rx_frame_err  <= !rx_s2;
                                    rx_parity_err <= rx_par_bad;
                                    rx_done       <= rx_s2 && !rx_par_bad;
                                    rx_state      <= rx_s2 ? RX_IDLE : RX_BREAK;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    uart_rx_fifo #(
        .DEPTH (RX_FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_done),
        .push_data (rx_shift),
        .pop       (rx_ready),
        .head      (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (rx_count)
    );

endmodule

// File: tb/tb_uart_transceiver.sv
// tb_uart_transceiver: self-checking bench for uart_transceiver at
// BAUD_DIV=4, OVERSAMPLE=16 (64 clk per bit), 8 data bits, 1 stop bit, depth 8.
// Frames are modelled as a list of line levels per bit index; received data
// is tracked in an expected-byte queue.
module tb_uart_transceiver;

    localparam int BAUD_DIV   = 4;
    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;
    localparam int PAR_ODD    = 0;
    localparam int DEPTH      = 8;
    localparam int BIT_CLK    = BAUD_DIV * OVERSAMPLE;
`ifdef UART_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_BITS = 1 + DATA_BITS + PAR_BITS + STOP_BITS;
    localparam int STOP_IDX   = 1 + DATA_BITS + PAR_BITS;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [3:0] rx_count;
    logic       rx_frame_err;
    logic       rx_parity_err;
    logic       rx_overrun;
    logic       uart_rx;
    logic       uart_tx;
    logic       rx_line = 1'b1;
    logic       loopback = 1'b0;

    assign uart_rx = loopback ? uart_tx : rx_line;

    always #5 clk = ~clk;

    uart_transceiver #(
        .BAUD_DIV      (BAUD_DIV),
        .OVERSAMPLE    (OVERSAMPLE),
        .DATA_BITS     (DATA_BITS),
        .STOP_BITS     (STOP_BITS),
        .PARITY_ODD    (PAR_ODD),
        .RX_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_count      (rx_count),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err),
        .rx_overrun    (rx_overrun),
        .uart_rx       (uart_rx),
        .uart_tx       (uart_tx)
    );

    int n_pass = 0;
    int n_total = 0;
    int ferr_n = 0;
    int perr_n = 0;
    int ovr_n = 0;
    logic [7:0] exp_q[$];

    // Every clock the pulse outputs are high adds one; a proper pulse adds exactly one.
    always @(negedge clk) begin
        if (rx_frame_err === 1'b1)  ferr_n++;
        if (rx_parity_err === 1'b1) perr_n++;
        if (rx_overrun === 1'b1)    ovr_n++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Line level of bit b of a frame carrying d: start, data LSB first, [parity], stops.
    function automatic logic model_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= DATA_BITS) return d[b-1];
        if (PAR_BITS == 1 && b == DATA_BITS + 1)
            return logic'(($countones(d) + PAR_ODD) % 2);
        return 1'b1;
    endfunction

    // Offer d on the TX port, then check every clk of the serial waveform and tx_ready timing.
    task automatic send_tx(input logic [7:0] d, input string tag);
        int waited;
        int bad;
        int ready_hi;
        @(negedge clk);
        waited = 0;
        while (tx_ready !== 1'b1 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check({tag, " ready drop"}, tx_ready, 1'b0);
        waited = 0;
        while (uart_tx !== 1'b0 && waited < 3 * BAUD_DIV) begin
            @(negedge clk);
            waited++;
        end
        check({tag, " start seen"}, uart_tx, 1'b0);
        ready_hi = 0;
        for (int b = 0; b < FRAME_BITS; b++) begin
            bad = 0;
            for (int c = 0; c < BIT_CLK; c++) begin
                if (uart_tx !== model_bit(d, b)) bad++;
                if (tx_ready !== 1'b0) ready_hi++;
                @(negedge clk);
            end
            check($sformatf("%s bit%0d bad samples", tag, b), bad, 0);
        end
        check({tag, " ready during frame"}, ready_hi, 0);
        check({tag, " ready after frame"}, tx_ready, 1'b1);
    endtask

    // Drive one serial frame on uart_rx, optionally with a bad stop bit or flipped parity.
    task automatic drive_rx(input logic [7:0] d, input logic stop_val, input logic par_flip);
        for (int b = 0; b < FRAME_BITS; b++) begin
            if (b == STOP_IDX) rx_line = stop_val;
            else if (PAR_BITS == 1 && b == DATA_BITS + 1) rx_line = model_bit(d, b) ^ par_flip;
            else rx_line = model_bit(d, b);
            repeat (BIT_CLK) @(negedge clk);
        end
        rx_line = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    // Pop everything, comparing against the expected queue in order.
    task automatic drain(input string tag);
        int guard;
        logic [31:0] exp;
        guard = 0;
        @(negedge clk);
        while (rx_valid === 1'b1 && guard < 4 * DEPTH) begin
            exp = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD0000;
            check($sformatf("%s pop%0d data", tag, guard), rx_data, exp);
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
            guard++;
        end
        check({tag, " undelivered"}, exp_q.size(), 0);
        check({tag, " count after drain"}, rx_count, 0);
        exp_q.delete();
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        logic       exp_push;
        logic       exp_ferr;
    } rxvec_t;

    rxvec_t tbl[5];
    int c0, f0, p0, o0, g;
    logic [7:0] d;

    initial begin
        tbl[0] = '{8'h55, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{8'h80, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{8'h01, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{8'hFF, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{8'h3C, 1'b1, 1'b1, 1'b0};

        #1 reset = 1'b1;
        repeat (5) @(negedge clk);
        check("reset uart_tx", uart_tx, 1'b1);
        check("reset tx_ready", tx_ready, 1'b1);
        check("reset rx_valid", rx_valid, 1'b0);
        check("reset rx_count", rx_count, 0);
        check("reset err pulses", {rx_frame_err, rx_parity_err, rx_overrun}, 3'b000);
        reset = 1'b0;

        // Waveform of a known byte
        send_tx(8'hA5, "tx A5");
`ifdef UART_PARITY_EN
        send_tx(8'h03, "tx 03 par");
`endif

        // Loopback, fixed then random bytes
        loopback = 1'b1;
        f0 = ferr_n; p0 = perr_n; o0 = ovr_n;
        send_tx(8'h00, "lb 00"); exp_q.push_back(8'h00);
        send_tx(8'hFF, "lb FF"); exp_q.push_back(8'hFF);
        send_tx(8'h5A, "lb 5A"); exp_q.push_back(8'h5A);
        repeat (8) @(negedge clk);
        check("lb count", rx_count, 3);
        check("lb no errors", (ferr_n - f0) + (perr_n - p0) + (ovr_n - o0), 0);
        drain("lb");
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom_range(0, 255));
            send_tx(d, $sformatf("lbr%0d", i));
            exp_q.push_back(d);
        end
        repeat (8) @(negedge clk);
        check("lbr count", rx_count, 4);
        drain("lbr");
        loopback = 1'b0;

        // Table: good and bad-stop frames on the serial input
        for (int i = 0; i < 5; i++) begin
            c0 = int'(rx_count);
            f0 = ferr_n;
            drive_rx(tbl[i].data, tbl[i].stop_ok, 1'b0);
            check($sformatf("tbl%0d count delta", i), int'(rx_count) - c0, 32'(tbl[i].exp_push));
            check($sformatf("tbl%0d ferr pulses", i), ferr_n - f0, 32'(tbl[i].exp_ferr));
            if (tbl[i].exp_push) exp_q.push_back(tbl[i].data);
        end
        drain("tbl");

        // Short low glitch must be rejected, receiver must still work afterwards
        f0 = ferr_n; p0 = perr_n; o0 = ovr_n;
        rx_line = 1'b0;
        repeat (8) @(negedge clk);
        rx_line = 1'b1;
        repeat (3 * BIT_CLK) @(negedge clk);
        check("glitch count", rx_count, 0);
        check("glitch no errors", (ferr_n - f0) + (perr_n - p0) + (ovr_n - o0), 0);
        d = 8'($urandom_range(0, 255));
        drive_rx(d, 1'b1, 1'b0);
        exp_q.push_back(d);
        check("post-glitch count", rx_count, 1);
        drain("glitch");

        // Overrun: fill, overflow, then pop and push in the same clk at full
        for (int i = 0; i < DEPTH; i++) begin
            d = 8'($urandom_range(0, 255));
            drive_rx(d, 1'b1, 1'b0);
            exp_q.push_back(d);
        end
        check("fill count", rx_count, DEPTH);
        o0 = ovr_n;
        drive_rx(8'($urandom_range(0, 255)), 1'b1, 1'b0);
        check("overrun pulse", ovr_n - o0, 1);
        check("overrun count", rx_count, DEPTH);
        d = 8'($urandom_range(0, 255));
        fork
            drive_rx(d, 1'b1, 1'b0);
            begin
                // Internal push strobe used only to time the pop onto the push clk.
                g = 0;
                @(negedge clk);
                while (dut.rx_done !== 1'b1 && g < (FRAME_BITS + 1) * BIT_CLK) begin
                    @(negedge clk);
                    g++;
                end
                check("full push strobe seen", dut.rx_done, 1'b1);
                check("full pop data", rx_data, 32'(exp_q.pop_front()));
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        exp_q.push_back(d);
        check("pop+push count", rx_count, DEPTH);
        check("pop+push no overrun", ovr_n - o0, 1);
        drain("ovr");

`ifdef UART_PARITY_EN
        p0 = perr_n;
        drive_rx(8'h03, 1'b1, 1'b1);
        check("parity err pulse", perr_n - p0, 1);
        check("parity err dropped", rx_count, 0);
        drive_rx(8'h03, 1'b1, 1'b0);
        exp_q.push_back(8'h03);
        check("parity ok pulse", perr_n - p0, 1);
        drain("par");
`endif

        // Reset in the middle of TX data bit 3 (0xA5 bit 3 is 0), with data in the FIFO
        drive_rx(8'h77, 1'b1, 1'b0);
        @(negedge clk);
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        g = 0;
        while (uart_tx !== 1'b0 && g < 3 * BAUD_DIV) begin
            @(negedge clk);
            g++;
        end
        repeat (4 * BIT_CLK + BIT_CLK / 2) @(negedge clk);
        check("pre-reset data bit3", uart_tx, 1'b0);
        check("pre-reset rx_count", rx_count, 1);
        #2 reset = 1'b1;
        #1;
        check("async reset uart_tx", uart_tx, 1'b1);
        check("async reset tx_ready", tx_ready, 1'b1);
        check("async reset rx_valid", rx_valid, 1'b0);
        check("async reset rx_count", rx_count, 0);
        @(negedge clk);
        reset = 1'b0;
        send_tx(8'hA5, "tx after reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
